// File: rtl/addr_decoder.sv
// addr_decoder: serial slave-ID address decoder between a granted bus master
// and three slaves. A two-bit slave ID arrives MSB first on mwdata. The block
// then waits a bounded number of cycles for the target slave to be ready.
// On success it acknowledges and forwards mvalid to that slave until the
// slave finishes, meaning it goes not-ready and then ready again.
module addr_decoder #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       bgrant,
    input  logic       mvalid,
    input  logic       mwdata,
    input  logic       sready1,
    input  logic       sready2,
    input  logic       sready3,
    output logic       mvalid1,
    output logic       mvalid2,
    output logic       mvalid3,
    output logic [1:0] ssel,
    output logic       ack,
    output logic       nack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        CONNECT = 2'd2,
        ACTIVE  = 2'd3
    } state_t;

    // Last counter value of the wait window; CONNECT lasts TIMEOUT cycles in total.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [1:0] id;
    logic [7:0] cnt;
    logic       busy;
    logic [1:0] tgt_idx;
    logic       tgt_ready;

    // Ready of one slave selected by index; index 3 names no slave.
    function automatic logic pick_ready(input logic [1:0] idx,
                                        input logic r1, input logic r2, input logic r3);
        logic r;
        case (idx)
            2'd0:    r = r1;
            2'd1:    r = r2;
            2'd2:    r = r3;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Target slave readiness: the decoded ID while connecting, the latched select once active.
    always_comb begin
        tgt_idx   = (state == ACTIVE) ? ssel : id;
        tgt_ready = pick_ready(tgt_idx, sready1, sready2, sready3);
    end

    // Forward mvalid only to the selected slave, and only while the connection is active.
    always_comb begin
        mvalid1 = 1'b0;
        mvalid2 = 1'b0;
        mvalid3 = 1'b0;
        if (state == ACTIVE) begin
            mvalid1 = mvalid && (ssel == 2'd0);
            mvalid2 = mvalid && (ssel == 2'd1);
            mvalid3 = mvalid && (ssel == 2'd2);
        end
    end

    // Control FSM: ID capture, wait for target ready with timeout, active-transfer tracking.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            id    <= 2'd0;
            cnt   <= 8'd0;
            busy  <= 1'b0;
            ssel  <= 2'd0;
            ack   <= 1'b0;
            nack  <= 1'b0;
        end else begin
            ack  <= 1'b0;
            nack <= 1'b0;
            if (state != IDLE && !bgrant) begin
                // Losing the grant aborts silently from any busy state.
                state <= IDLE;
                cnt   <= 8'd0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bgrant && mvalid) begin
                            id[1] <= mwdata;
                            state <= ADDR;
                        end
                    end
                    ADDR: begin
                        if (mvalid) begin
                            id[0] <= mwdata;
                            cnt   <= 8'd0;
                            state <= CONNECT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    CONNECT: begin
                        if (id == 2'd3) begin
                            nack  <= 1'b1;
                            cnt   <= 8'd0;
                            state <= IDLE;
                        end else if (tgt_ready) begin
                            ssel  <= id;
                            ack   <= 1'b1;
                            cnt   <= 8'd0;
                            busy  <= 1'b0;
                            state <= ACTIVE;
                        end else if (cnt == CNT_LAST) begin
                            nack  <= 1'b1;
                            cnt   <= 8'd0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    ACTIVE: begin
                        if (!tgt_ready) begin
                            busy <= 1'b1;
                        end else if (busy) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_addr_decoder.sv
// Directed bench for addr_decoder: ID decode, ack/nack pulses, timeout,
// active-phase gating, grant loss and reset abort.
module tb_addr_decoder;

    logic       clk = 1'b0;
    logic       rstn;
    logic       bgrant;
    logic       mvalid;
    logic       mwdata;
    logic       sready1, sready2, sready3;
    logic       mvalid1, mvalid2, mvalid3;
    logic [1:0] ssel;
    logic       ack, nack;

    int tests = 0;
    int fails = 0;

    addr_decoder #(.TIMEOUT(16)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bgrant  (bgrant),
        .mvalid  (mvalid),
        .mwdata  (mwdata),
        .sready1 (sready1),
        .sready2 (sready2),
        .sready3 (sready3),
        .mvalid1 (mvalid1),
        .mvalid2 (mvalid2),
        .mvalid3 (mvalid3),
        .ssel    (ssel),
        .ack     (ack),
        .nack    (nack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the three forwarded valids packed as {mvalid3, mvalid2, mvalid1}.
    task automatic chk_mv(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, mvalid3, mvalid2, mvalid1}, {29'd0, exp});
    endtask

    task automatic chk_pulses(input string tag, input logic exp_ack, input logic exp_nack);
        chk({tag, "_ack"}, {31'd0, ack}, {31'd0, exp_ack});
        chk({tag, "_nack"}, {31'd0, nack}, {31'd0, exp_nack});
    endtask

    // Shift in a two-bit ID over two edges; leaves the DUT in CONNECT.
    task automatic send_id(input logic b1, input logic b0);
        bgrant = 1'b1; mvalid = 1'b1; mwdata = b1;
        step();
        mwdata = b0;
        step();
        mvalid = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; bgrant = 1'b0; mvalid = 1'b0; mwdata = 1'b0;
        sready1 = 1'b0; sready2 = 1'b0; sready3 = 1'b0;
        step(); step();
        chk_pulses("rst", 1'b0, 1'b0);
        chk("rst_ssel", {30'd0, ssel}, 32'd0);
        mvalid = 1'b1; #1;
        chk_mv("rst_mv", 3'b000);
        mvalid = 1'b0;
        rstn = 1'b1;
        step();

        // id=2, slave 3 ready: ack on the third edge after the first ID bit.
        sready3 = 1'b1;
        bgrant = 1'b1; mvalid = 1'b1; mwdata = 1'b1;
        step();
        chk_pulses("a_e1", 1'b0, 1'b0);
        mwdata = 1'b0;
        step();
        chk_pulses("a_e2", 1'b0, 1'b0);
        step();
        chk_pulses("a_e3", 1'b1, 1'b0);
        chk("a_ssel", {30'd0, ssel}, 32'd2);
        chk_mv("a_mv_hi", 3'b100);
        mvalid = 1'b0; #1;
        chk_mv("a_mv_lo", 3'b000);
        step();
        chk_pulses("a_e4", 1'b0, 1'b0);
        sready3 = 1'b0;
        step();
        sready3 = 1'b1;
        step();
        bgrant = 1'b0; mvalid = 1'b1; #1;
        chk_mv("a_idle_mv", 3'b000);
        mvalid = 1'b0;
        step();

        // id=3: nack pulse, no forwarding, ssel retained.
        sready1 = 1'b1; sready2 = 1'b1; sready3 = 1'b1;
        send_id(1'b1, 1'b1);
        step();
        chk_pulses("b_nack", 1'b0, 1'b1);
        chk("b_ssel", {30'd0, ssel}, 32'd2);
        bgrant = 1'b0; mvalid = 1'b1; #1;
        chk_mv("b_mv", 3'b000);
        mvalid = 1'b0;
        step();
        chk_pulses("b_after", 1'b0, 1'b0);

        // id=0, slave 1 never ready: nack after exactly 16 CONNECT cycles.
        sready1 = 1'b0; sready2 = 1'b1; sready3 = 1'b1;
        send_id(1'b0, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk_pulses($sformatf("c_wait%0d", i), 1'b0, 1'b0);
        end
        step();
        chk_pulses("c_timeout", 1'b0, 1'b1);
        step();
        chk_pulses("c_after", 1'b0, 1'b0);

        // id=0, slave 1 ready during the 10th CONNECT cycle: ack, no nack.
        send_id(1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            step();
        end
        chk_pulses("c2_pre", 1'b0, 1'b0);
        sready1 = 1'b1;
        step();
        chk_pulses("c2_ack", 1'b1, 1'b0);
        chk("c2_ssel", {30'd0, ssel}, 32'd0);
        mvalid = 1'b1; #1;
        chk_mv("c2_mv", 3'b001);
        mvalid = 1'b0;
        bgrant = 1'b0;
        step();
        step();
        chk_pulses("c2_post", 1'b0, 1'b0);

        // id=1 on slave 2: 5 busy cycles with other slaves toggling, then end.
        sready1 = 1'b0; sready2 = 1'b1; sready3 = 1'b0;
        send_id(1'b0, 1'b1);
        step();
        chk_pulses("d_ack", 1'b1, 1'b0);
        chk("d_ssel", {30'd0, ssel}, 32'd1);
        mvalid = 1'b1;
        sready2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sready1 = ~sready1; sready3 = ~sready3;
            step();
        end
        chk_mv("d_busy_mv", 3'b010);
        chk_pulses("d_busy", 1'b0, 1'b0);
        sready2 = 1'b1;
        step();
        chk_mv("d_end_mv", 3'b000);
        chk_pulses("d_end", 1'b0, 1'b0);
        bgrant = 1'b0; mvalid = 1'b0;
        step();

        // Grant lost in ACTIVE: idle next cycle, ssel kept, no pulses.
        sready1 = 1'b0; sready2 = 1'b1; sready3 = 1'b0;
        send_id(1'b0, 1'b1);
        step();
        chk_pulses("e_ack", 1'b1, 1'b0);
        mvalid = 1'b1; #1;
        chk_mv("e_mv_on", 3'b010);
        bgrant = 1'b0;
        step();
        chk_mv("e_mv_off", 3'b000);
        chk("e_ssel", {30'd0, ssel}, 32'd1);
        chk_pulses("e_drop", 1'b0, 1'b0);
        mvalid = 1'b0;

        // ADDR with mvalid low returns to IDLE: no connection despite ready slaves.
        sready1 = 1'b1; sready2 = 1'b1; sready3 = 1'b1;
        bgrant = 1'b1; mvalid = 1'b1; mwdata = 1'b1;
        step();
        mvalid = 1'b0;
        step(); step();
        chk_pulses("g_abort", 1'b0, 1'b0);

        // Reset while in CONNECT: reset values next cycle, no nack later.
        sready1 = 1'b0; sready2 = 1'b0; sready3 = 1'b0;
        send_id(1'b1, 1'b0);
        step();
        rstn = 1'b0;
        step();
        chk_pulses("f_rst", 1'b0, 1'b0);
        chk("f_ssel", {30'd0, ssel}, 32'd0);
        mvalid = 1'b1; #1;
        chk_mv("f_mv", 3'b000);
        mvalid = 1'b0;
        rstn = 1'b1; bgrant = 1'b1;
        for (int i = 0; i < 18; i++) begin
            step();
        end
        chk_pulses("f_quiet", 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
